exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Multi-cycle instruction sequencer for the NPC core. It drives the fetch and load/store bus handshakes, steps each instruction through fetch, execute, memory and writeback, and emits the single-cycle write enables for the instruction latch, register file and next-PC register (`i_bru_npc_wen` of the branch unit). It also provides a bus watchdog, halt-on-ebreak, and a retired-instruction counter.

## Interface
- `CPU_Width`, 32: width of the retire counter.
- `TIMEOUT`, 255: maximum number of cycles spent in any bus-wait state before a bus error is declared. Legal range is 1..65535.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `o_ifu_req` output 1: fetch request. Held high until granted.
- `i_ifu_gnt` input 1: fetch request accepted.
- `i_ifu_rvalid` input 1: instruction data valid (single-cycle pulse).
- `i_idu_is_load`, `i_idu_is_store`, `i_idu_ebreak`, `i_idu_rd_wen` input 1 each: decode results. These are sampled only in the EXEC state.
- `o_lsu_req` output 1: data-bus request. Held high until granted.
- `i_lsu_gnt` input 1: data request accepted.
- `i_lsu_done` input 1: load data or store completion (single-cycle pulse).
- `i_bus_err` input 1: error response from either bus.
- `o_inst_wen` output 1: latch the fetched instruction.
- `o_rf_wen` output 1: register-file write enable.
- `o_npc_wen` output 1: next-PC register write enable.
- `o_halt` output 1: core halted (sticky).
- `o_bus_err` output 1: bus error or timeout (sticky).
- `o_retire_cnt` output `CPU_Width`: number of retired instructions.
- `o_state` output 3: current FSM state, for debug.

## Operation
- FSM states and their 3-bit encodings:
  - IF_REQ = 0
  - IF_WAIT = 1
  - EXEC = 2
  - MEM_REQ = 3
  - MEM_WAIT = 4
  - WB = 5
  - HALT = 6
  - ERR = 7
- State transitions:
  - **IF_REQ:** `o_ifu_req` = 1. `i_ifu_gnt` → IF_WAIT.
  - **IF_WAIT:** `i_ifu_rvalid` → EXEC. `o_inst_wen` = `i_ifu_rvalid`, asserted combinationally in this state only.
  - **EXEC:** one cycle. Priority order:
    - `i_idu_ebreak` → HALT.
    - else load or store → MEM_REQ.
    - else → WB.
  - **MEM_REQ:** `o_lsu_req` = 1. `i_lsu_gnt` → MEM_WAIT.
  - **MEM_WAIT:** `i_lsu_done` → WB.
  - **WB:** one cycle, then → IF_REQ.
    - `o_npc_wen` = 1.
    - `o_rf_wen` = `i_idu_rd_wen` & ~store. This uses the decode flags registered in EXEC.
    - `o_retire_cnt` increments.
  - **HALT:** terminal. `o_halt` = 1. No request or enable outputs are asserted.
  - **ERR:** terminal. `o_bus_err` = 1. No request or enable outputs are asserted.
- Bus-error and timeout handling:
  - `i_bus_err` in any of IF_REQ, IF_WAIT, MEM_REQ or MEM_WAIT → ERR. This takes priority over every other transition.
  - `i_bus_err` in other states is ignored.
- Watchdog:
  - A 16-bit counter is cleared on every state change and increments every cycle spent in IF_REQ, IF_WAIT, MEM_REQ or MEM_WAIT.
  - When the counter equals `TIMEOUT - 1` and the state would not change in that cycle → ERR on the next edge.
  - A grant or done arriving in the same cycle as the timeout wins.
- Decode flags are registered on entry to EXEC and held until WB, so the IDU inputs need only be valid during EXEC.
- `i_ifu_gnt` and `i_ifu_rvalid` in the same IF_REQ cycle: only the grant is honoured. The IFU must present `rvalid` no earlier than the cycle after the grant; the same rule applies to `i_lsu_gnt` and `i_lsu_done`.
- `o_retire_cnt` wraps from all-ones to 0 without a flag.

## Timing
- Reset (`rst` = 0) takes effect asynchronously and produces:
  - state = IF_REQ;
  - all outputs 0 except `o_ifu_req` = 1 and `o_state` = 0;
  - `o_retire_cnt` = 0, watchdog = 0, `o_halt` = `o_bus_err` = 0.
- Release of reset is synchronous to `clk`, and the first fetch request is visible immediately after release. Reset asserted mid-instruction aborts it, and no `o_npc_wen` is produced for that instruction.
- All outputs are decoded from registered state (Moore), except `o_inst_wen`, which also depends on `i_ifu_rvalid`.
- Minimum instruction latencies, with grant in the first cycle and data in the next:
  - ALU instruction: 4 cycles (IF_REQ, IF_WAIT, EXEC, WB).
  - Load or store: 6 cycles.
- `o_npc_wen` is high for exactly one cycle per retired instruction. The NPC register therefore holds the new PC on the first cycle of the next IF_REQ.
- A halted instruction (ebreak) produces no `o_npc_wen` and is not counted.

## Test plan
- **Reset, then one ALU instruction.** Grant in cycle 0, `rvalid` in cycle 1, no decode flags → `o_inst_wen` in cycle 1, `o_npc_wen` = `o_rf_wen` = 1 in cycle 3 only, `o_retire_cnt` = 1, `o_ifu_req` high again in cycle 4.
- **Load with 3 wait cycles.** 3 wait cycles before `i_lsu_gnt` and 2 before `i_lsu_done` → `o_lsu_req` held for 4 cycles, WB occurs 1 cycle after done, `o_rf_wen` = 1.
- **Store with `i_idu_rd_wen` = 1** → `o_rf_wen` stays 0 in WB and `o_npc_wen` = 1.
- **ebreak after 5 instructions** → `o_halt` = 1 and sticky, `o_retire_cnt` = 5, no further `o_ifu_req`.
- **Watchdog.** `TIMEOUT` = 4, no grant → ERR after exactly 4 cycles in IF_REQ, `o_bus_err` = 1. Repeat with the grant in the 4th cycle → no error.
- **Error and reset cases.**
  - `i_bus_err` in MEM_WAIT → ERR and no `o_npc_wen`.
  - Reset asserted in MEM_WAIT → all outputs return immediately to their reset values.

Source files
------------

// File: rtl/exec_sequencer_if.sv
// Fetch and load/store bus handshake bundle between the sequencer and the IFU/LSU.
// The master side issues requests; the slave side grants, completes and reports errors.
interface exec_sequencer_if;
    logic o_ifu_req;
    logic i_ifu_gnt;
    logic i_ifu_rvalid;
    logic o_lsu_req;
    logic i_lsu_gnt;
    logic i_lsu_done;
    logic i_bus_err;

    modport master (
        output o_ifu_req,
        output o_lsu_req,
        input  i_ifu_gnt,
        input  i_ifu_rvalid,
        input  i_lsu_gnt,
        input  i_lsu_done,
        input  i_bus_err
    );

    modport slave (
        input  o_ifu_req,
        input  o_lsu_req,
        output i_ifu_gnt,
        output i_ifu_rvalid,
        output i_lsu_gnt,
        output i_lsu_done,
        output i_bus_err
    );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: fetch, execute, memory and writeback stepping
// with a bus watchdog, halt-on-ebreak and a retired-instruction counter.
module exec_sequencer #(
    parameter int CPU_Width = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    exec_sequencer_if.master     bus,
    input  logic                 i_idu_is_load,
    input  logic                 i_idu_is_store,
    input  logic                 i_idu_ebreak,
    input  logic                 i_idu_rd_wen,
    output logic                 o_inst_wen,
    output logic                 o_rf_wen,
    output logic                 o_npc_wen,
    output logic                 o_halt,
    output logic                 o_bus_err,
    output logic [CPU_Width-1:0] o_retire_cnt,
    output logic [2:0]           o_state
);

    typedef enum logic [2:0] {
        IF_REQ   = 3'd0,
        IF_WAIT  = 3'd1,
        EXEC     = 3'd2,
        MEM_REQ  = 3'd3,
        MEM_WAIT = 3'd4,
        WB       = 3'd5,
        HALT     = 3'd6,
        ERR      = 3'd7
    } state_t;

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    state_t      nominal_next;
    logic        in_wait;
    logic [15:0] wd_cnt;
    logic [15:0] wd_next;
    logic        store_q;
    logic        rd_wen_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IF_REQ;
            wd_cnt       <= '0;
            store_q      <= 1'b0;
            rd_wen_q     <= 1'b0;
            o_retire_cnt <= '0;
        end else begin
            state  <= state_next;
            wd_cnt <= wd_next;
            if (state == EXEC) begin
                store_q  <= i_idu_is_store;
                rd_wen_q <= i_idu_rd_wen;
            end
            if (state == WB) begin
                o_retire_cnt <= o_retire_cnt + CPU_Width'(1);
            end
        end
    end

    // Bus errors beat everything; a timeout only fires when no handshake moves us on.
    always_comb begin
        nominal_next = state;
        case (state)
            IF_REQ:   if (bus.i_ifu_gnt)    nominal_next = IF_WAIT;
            IF_WAIT:  if (bus.i_ifu_rvalid) nominal_next = EXEC;
            EXEC: begin
                if (i_idu_ebreak)                         nominal_next = HALT;
                else if (i_idu_is_load || i_idu_is_store) nominal_next = MEM_REQ;
                else                                      nominal_next = WB;
            end
            MEM_REQ:  if (bus.i_lsu_gnt)    nominal_next = MEM_WAIT;
            MEM_WAIT: if (bus.i_lsu_done)   nominal_next = WB;
            WB:       nominal_next = IF_REQ;
            default:  nominal_next = state;
        endcase

        in_wait = (state == IF_REQ) || (state == IF_WAIT) ||
                  (state == MEM_REQ) || (state == MEM_WAIT);

        state_next = nominal_next;
        if (in_wait && bus.i_bus_err) begin
            state_next = ERR;
        end else if (in_wait && (nominal_next == state) && (wd_cnt == WD_LIMIT)) begin
            state_next = ERR;
        end

        wd_next = '0;
        if (in_wait && (state_next == state)) begin
            wd_next = wd_cnt + 16'd1;
        end
    end

    assign bus.o_ifu_req = (state == IF_REQ);
    assign bus.o_lsu_req = (state == MEM_REQ);
    assign o_inst_wen    = (state == IF_WAIT) && bus.i_ifu_rvalid;
    assign o_npc_wen     = (state == WB);
    assign o_rf_wen      = (state == WB) && rd_wen_q && !store_q;
    assign o_halt        = (state == HALT);
    assign o_bus_err     = (state == ERR);
    assign o_state       = state;

endmodule

// File: tb/tb_exec_sequencer.sv
// Cycle-vector bench for exec_sequencer with a retire scoreboard checked on every o_npc_wen.
module tb_exec_sequencer;

    localparam logic [8:0] S_NONE  = 9'h000;
    localparam logic [8:0] S_IGNT  = 9'h100;
    localparam logic [8:0] S_RVAL  = 9'h080;
    localparam logic [8:0] S_LGNT  = 9'h040;
    localparam logic [8:0] S_LDONE = 9'h020;
    localparam logic [8:0] S_BERR  = 9'h010;
    localparam logic [8:0] S_LD    = 9'h008;
    localparam logic [8:0] S_ST    = 9'h004;
    localparam logic [8:0] S_EB    = 9'h002;
    localparam logic [8:0] S_RDW   = 9'h001;

    // Output bits: {ifu_req, lsu_req, inst_wen, rf_wen, npc_wen, halt, bus_err}
    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_IFREQ = 7'b1000000;
    localparam logic [6:0] O_LSU   = 7'b0100000;
    localparam logic [6:0] O_IWEN  = 7'b0010000;
    localparam logic [6:0] O_WB_RF = 7'b0001100;
    localparam logic [6:0] O_WB    = 7'b0000100;
    localparam logic [6:0] O_HALT  = 7'b0000010;
    localparam logic [6:0] O_ERR   = 7'b0000001;

    typedef struct {
        logic [8:0] stim;
        logic [2:0] st;
        logic [6:0] outs;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        is_load;
    logic        is_store;
    logic        ebreak;
    logic        rd_wen;
    logic        inst_wen;
    logic        rf_wen;
    logic        npc_wen;
    logic        halt;
    logic        bus_err;
    logic [31:0] retire_cnt;
    logic [2:0]  state;

    int          n_vec;
    int          n_miss;
    int          exp_count;
    bit          expect_retire;
    logic [32:0] sb[$];
    vec_t        tbl[$];

    exec_sequencer_if bus_if ();

    exec_sequencer #(.CPU_Width(32), .TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus_if.master),
        .i_idu_is_load  (is_load),
        .i_idu_is_store (is_store),
        .i_idu_ebreak   (ebreak),
        .i_idu_rd_wen   (rd_wen),
        .o_inst_wen     (inst_wen),
        .o_rf_wen       (rf_wen),
        .o_npc_wen      (npc_wen),
        .o_halt         (halt),
        .o_bus_err      (bus_err),
        .o_retire_cnt   (retire_cnt),
        .o_state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [8:0] s, input logic [2:0] st, input logic [6:0] o);
        vec_t v;
        v.stim = s;
        v.st   = st;
        v.outs = o;
        return v;
    endfunction

    function automatic logic [6:0] dut_outs();
        return {bus_if.o_ifu_req, bus_if.o_lsu_req, inst_wen, rf_wen, npc_wen, halt, bus_err};
    endfunction

    task automatic check_output(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive one cycle, check it, advance to the next falling edge.
    task automatic apply_stimulus(input string name, input vec_t v);
        bus_if.i_ifu_gnt    = v.stim[8];
        bus_if.i_ifu_rvalid = v.stim[7];
        bus_if.i_lsu_gnt    = v.stim[6];
        bus_if.i_lsu_done   = v.stim[5];
        bus_if.i_bus_err    = v.stim[4];
        is_load             = v.stim[3];
        is_store            = v.stim[2];
        ebreak              = v.stim[1];
        rd_wen              = v.stim[0];
        if (v.st == 3'd2 && !v.stim[1] && expect_retire) begin
            sb.push_back({v.stim[0] & ~v.stim[2], 32'(exp_count)});
            exp_count++;
        end
        #1;
        check_output(name, 40'({state, dut_outs()}), 40'({v.st, v.outs}));
        @(negedge clk);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b0;
        bus_if.i_ifu_gnt    = 1'b0;
        bus_if.i_ifu_rvalid = 1'b0;
        bus_if.i_lsu_gnt    = 1'b0;
        bus_if.i_lsu_done   = 1'b0;
        bus_if.i_bus_err    = 1'b0;
        {is_load, is_store, ebreak, rd_wen} = 4'b0000;
        sb.delete();
        exp_count = 0;
        #1;
        check_output(name, 40'({state, dut_outs(), retire_cnt}), 40'({3'd0, O_IFREQ, 32'd0}));
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_alu(input string name);
        apply_stimulus(name, mk(S_IGNT, 3'd0, O_IFREQ));
        apply_stimulus(name, mk(S_RVAL, 3'd1, O_IWEN));
        apply_stimulus(name, mk(S_RDW,  3'd2, O_NONE));
        apply_stimulus(name, mk(S_NONE, 3'd5, O_WB_RF));
    endtask

    // Scoreboard: each writeback must match the oldest outstanding expected retire.
    always @(negedge clk) begin
        #2;
        if (rst && npc_wen) begin
            if (sb.size() == 0) begin
                check_output("unexpected_npc_wen", 40'(1), 40'(0));
            end else begin
                check_output("retire", 40'({rf_wen, retire_cnt}), 40'(sb.pop_front()));
            end
        end
    end

    initial begin
        n_vec = 0;
        n_miss = 0;
        expect_retire = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        do_reset("reset_state");

        // ALU, load with waits, store with rd_wen, same-cycle gnt+rvalid, bus_err in EXEC
        tbl.push_back(mk(S_IGNT,         3'd0, O_IFREQ));
        tbl.push_back(mk(S_RVAL,         3'd1, O_IWEN));
        tbl.push_back(mk(S_RDW,          3'd2, O_NONE));
        tbl.push_back(mk(S_NONE,         3'd5, O_WB_RF));
        tbl.push_back(mk(S_IGNT,         3'd0, O_IFREQ));
        tbl.push_back(mk(S_RVAL,         3'd1, O_IWEN));
        tbl.push_back(mk(S_LD | S_RDW,   3'd2, O_NONE));
        tbl.push_back(mk(S_NONE,         3'd3, O_LSU));
        tbl.push_back(mk(S_NONE,         3'd3, O_LSU));
        tbl.push_back(mk(S_NONE,         3'd3, O_LSU));
        tbl.push_back(mk(S_LGNT,         3'd3, O_LSU));
        tbl.push_back(mk(S_NONE,         3'd4, O_NONE));
        tbl.push_back(mk(S_NONE,         3'd4, O_NONE));
        tbl.push_back(mk(S_LDONE,        3'd4, O_NONE));
        tbl.push_back(mk(S_NONE,         3'd5, O_WB_RF));
        tbl.push_back(mk(S_IGNT,         3'd0, O_IFREQ));
        tbl.push_back(mk(S_NONE,         3'd1, O_NONE));
        tbl.push_back(mk(S_RVAL,         3'd1, O_IWEN));
        tbl.push_back(mk(S_ST | S_RDW,   3'd2, O_NONE));
        tbl.push_back(mk(S_LGNT,         3'd3, O_LSU));
        tbl.push_back(mk(S_LDONE,        3'd4, O_NONE));
        tbl.push_back(mk(S_NONE,         3'd5, O_WB));
        tbl.push_back(mk(S_IGNT | S_RVAL, 3'd0, O_IFREQ));
        tbl.push_back(mk(S_NONE,         3'd1, O_NONE));
        tbl.push_back(mk(S_RVAL,         3'd1, O_IWEN));
        tbl.push_back(mk(S_BERR,         3'd2, O_NONE));
        tbl.push_back(mk(S_NONE,         3'd5, O_WB));
        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus($sformatf("table[%0d]", i), tbl[i]);
        end
        check_output("retire_after_table", 40'(retire_cnt), 40'(4));

        // Reset asserted mid-instruction in MEM_WAIT
        apply_stimulus("rst_mw", mk(S_IGNT, 3'd0, O_IFREQ));
        apply_stimulus("rst_mw", mk(S_RVAL, 3'd1, O_IWEN));
        apply_stimulus("rst_mw", mk(S_ST,   3'd2, O_NONE));
        apply_stimulus("rst_mw", mk(S_LGNT, 3'd3, O_LSU));
        #1;
        check_output("in_mem_wait", 40'(state), 40'(4));
        do_reset("reset_in_mem_wait");

        // Five instructions then ebreak
        for (int i = 0; i < 5; i++) begin
            run_alu($sformatf("pre_halt[%0d]", i));
        end
        apply_stimulus("ebreak", mk(S_IGNT, 3'd0, O_IFREQ));
        apply_stimulus("ebreak", mk(S_RVAL, 3'd1, O_IWEN));
        apply_stimulus("ebreak", mk(S_EB | S_LD | S_RDW, 3'd2, O_NONE));
        for (int i = 0; i < 3; i++) begin
            apply_stimulus("halt_sticky", mk(S_IGNT | S_BERR, 3'd6, O_HALT));
        end
        check_output("retire_at_halt", 40'(retire_cnt), 40'(5));

        // Watchdog: no grant for four cycles
        do_reset("reset_wd1");
        for (int i = 0; i < 4; i++) begin
            apply_stimulus("wd_wait", mk(S_NONE, 3'd0, O_IFREQ));
        end
        apply_stimulus("wd_err", mk(S_IGNT, 3'd7, O_ERR));
        apply_stimulus("wd_err", mk(S_NONE, 3'd7, O_ERR));

        // Watchdog: grant on the fourth cycle wins
        do_reset("reset_wd2");
        for (int i = 0; i < 3; i++) begin
            apply_stimulus("wd_late", mk(S_NONE, 3'd0, O_IFREQ));
        end
        apply_stimulus("wd_late", mk(S_IGNT, 3'd0, O_IFREQ));
        apply_stimulus("wd_late", mk(S_NONE, 3'd1, O_NONE));
        apply_stimulus("wd_late", mk(S_RVAL, 3'd1, O_IWEN));
        apply_stimulus("wd_late", mk(S_NONE, 3'd2, O_NONE));
        apply_stimulus("wd_late", mk(S_NONE, 3'd5, O_WB));
        check_output("retire_wd_late", 40'(retire_cnt), 40'(1));

        // Bus error during MEM_WAIT aborts without writeback
        do_reset("reset_berr");
        apply_stimulus("berr_mw", mk(S_IGNT, 3'd0, O_IFREQ));
        apply_stimulus("berr_mw", mk(S_RVAL, 3'd1, O_IWEN));
        expect_retire = 1'b0;
        apply_stimulus("berr_mw", mk(S_LD | S_RDW, 3'd2, O_NONE));
        expect_retire = 1'b1;
        apply_stimulus("berr_mw", mk(S_LGNT,  3'd3, O_LSU));
        apply_stimulus("berr_mw", mk(S_NONE,  3'd4, O_NONE));
        apply_stimulus("berr_mw", mk(S_BERR,  3'd4, O_NONE));
        apply_stimulus("berr_mw", mk(S_LDONE, 3'd7, O_ERR));
        apply_stimulus("berr_mw", mk(S_NONE,  3'd7, O_ERR));
        check_output("retire_berr", 40'(retire_cnt), 40'(0));

        #3;
        check_output("scoreboard_empty", 40'(sb.size()), 40'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
